// File: rtl/up_down_sweep_checker_pkg.sv
// Shared encodings for the up/down sweep checker: FSM states, error codes and
// the default counter width.
package up_down_pkg;

  localparam int UD_WIDTH = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_ISSUE,
    S_ARM,
    S_RISE,
    S_FALL,
    S_END,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_VALUE   = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_READY   = 2'd3
  } err_code_t;

endpackage

// File: rtl/up_down_sweep_checker_timer.sv
// Clearable cycle counter that saturates at TIMEOUT-1 and flags that terminal
// count; bounds how long the checker waits for the counter to go ready.
module sweep_timer #(
  parameter int TIMEOUT = 32
) (
  input  logic in_clock,
  input  logic in_reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TERM = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_count;
  logic          w_term;

  assign w_term = (r_count == TERM);
  assign o_term = w_term;

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_term) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/up_down_sweep_checker.sv
// Drives start pulses into the up/down sweep counter and checks every cycle of
// each sweep (0, 1..MAX, MAX-1..0, ready) for NUM_SWEEPS sweeps.
module up_down_sweep_checker
  import up_down_pkg::*;
#(
  parameter int WIDTH      = UD_WIDTH,
  parameter int NUM_SWEEPS = 3,
  parameter int TIMEOUT    = 32
) (
  input  logic                              in_clock,
  input  logic                              in_reset_n,
  input  logic                              in_go,
  input  logic                              in_ready,
  input  logic [WIDTH-1:0]                  in_value,
  output logic                              out_start,
  output logic                              out_busy,
  output logic                              out_done,
  output logic                              out_error,
  output logic [1:0]                        out_err_code,
  output logic [$clog2(NUM_SWEEPS+1)-1:0]   out_sweeps,
  output logic [WIDTH-1:0]                  out_fail_value
);

  localparam int SW = $clog2(NUM_SWEEPS + 1);
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_exp, w_exp_nx;
  logic             r_start, w_start_nx;
  logic             r_busy, w_busy_nx;
  logic             r_done, w_done_nx;
  logic             r_error, w_error_nx;
  logic [1:0]       r_code, w_code_nx;
  logic [SW-1:0]    r_sweeps, w_sweeps_nx, w_sweeps_inc;
  logic [WIDTH-1:0] r_fail, w_fail_nx;

  logic             w_raise;
  err_code_t        w_raise_code;
  logic             w_tmr_term;

  sweep_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .in_clock   (in_clock),
    .in_reset_n (in_reset_n),
    .i_clr      (r_state != S_WAIT_RDY),
    .i_en       ((r_state == S_WAIT_RDY) && !in_ready),
    .o_term     (w_tmr_term)
  );

  assign w_sweeps_inc = r_sweeps + 1'b1;

  always_comb begin
    w_state_nx   = r_state;
    w_exp_nx     = r_exp;
    w_start_nx   = 1'b0;
    w_busy_nx    = r_busy;
    w_done_nx    = r_done;
    w_error_nx   = r_error;
    w_code_nx    = r_code;
    w_sweeps_nx  = r_sweeps;
    w_fail_nx    = r_fail;
    w_raise      = 1'b0;
    w_raise_code = ERR_NONE;

    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (in_go) begin
          w_done_nx   = 1'b0;
          w_error_nx  = 1'b0;
          w_code_nx   = ERR_NONE;
          w_sweeps_nx = '0;
          w_fail_nx   = '0;
          w_busy_nx   = 1'b1;
          w_state_nx  = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (in_ready) begin
          w_start_nx = 1'b1;
          w_state_nx = S_ISSUE;
        end else if (w_tmr_term) begin
          w_raise      = 1'b1;
          w_raise_code = ERR_TIMEOUT;
        end
      end
      S_ISSUE: w_state_nx = S_ARM;
      S_ARM: begin
        if (in_value != '0) begin
          w_raise      = 1'b1;
          w_raise_code = ERR_VALUE;
        end else begin
          w_exp_nx   = WIDTH'(1);
          w_state_nx = S_RISE;
        end
      end
      // Value mismatch is checked before ready so it wins a same-cycle tie.
      S_RISE, S_FALL: begin
        if (in_value != r_exp) begin
          w_raise      = 1'b1;
          w_raise_code = ERR_VALUE;
        end else if (in_ready) begin
          w_raise      = 1'b1;
          w_raise_code = ERR_READY;
        end else if (r_state == S_RISE) begin
          if (r_exp == MAX) begin
            w_exp_nx   = MAX - 1'b1;
            w_state_nx = S_FALL;
          end else begin
            w_exp_nx = r_exp + 1'b1;
          end
        end else begin
          if (r_exp == '0) w_state_nx = S_END;
          else             w_exp_nx   = r_exp - 1'b1;
        end
      end
      S_END: begin
        if (!in_ready) begin
          w_raise      = 1'b1;
          w_raise_code = ERR_READY;
        end else begin
          w_sweeps_nx = w_sweeps_inc;
          if (w_sweeps_inc == SW'(NUM_SWEEPS)) begin
            w_done_nx  = 1'b1;
            w_busy_nx  = 1'b0;
            w_state_nx = S_DONE;
          end else begin
            w_state_nx = S_WAIT_RDY;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    // ERR only leaves on in_go, so the first error is the one that sticks.
    if (w_raise) begin
      w_state_nx = S_ERR;
      w_error_nx = 1'b1;
      w_busy_nx  = 1'b0;
      w_code_nx  = w_raise_code;
      if (w_raise_code == ERR_VALUE) w_fail_nx = in_value;
    end
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_state  <= S_IDLE;
      r_exp    <= '0;
      r_start  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_code   <= '0;
      r_sweeps <= '0;
      r_fail   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_exp    <= w_exp_nx;
      r_start  <= w_start_nx;
      r_busy   <= w_busy_nx;
      r_done   <= w_done_nx;
      r_error  <= w_error_nx;
      r_code   <= w_code_nx;
      r_sweeps <= w_sweeps_nx;
      r_fail   <= w_fail_nx;
    end
  end

  assign out_start      = r_start;
  assign out_busy       = r_busy;
  assign out_done       = r_done;
  assign out_error      = r_error;
  assign out_err_code   = r_code;
  assign out_sweeps     = r_sweeps;
  assign out_fail_value = r_fail;

endmodule

// File: tb/tb_up_down_sweep_checker.sv
// Bench for up_down_sweep_checker: a behavioural sweep counter with per-cycle
// value/ready overrides, a scenario table, and hand sequences for timing corners.
module tb_up_down_sweep_checker;

  logic       in_clock   = 1'b0;
  logic       in_reset_n = 1'b1;
  logic       in_go      = 1'b0;
  logic       in_ready;
  logic [3:0] in_value;
  logic       out_start, out_busy, out_done, out_error;
  logic [1:0] out_err_code;
  logic [1:0] out_sweeps;
  logic [3:0] out_fail_value;

  up_down_sweep_checker #(.WIDTH(4), .NUM_SWEEPS(3), .TIMEOUT(32)) dut (
    .in_clock       (in_clock),
    .in_reset_n     (in_reset_n),
    .in_go          (in_go),
    .in_ready       (in_ready),
    .in_value       (in_value),
    .out_start      (out_start),
    .out_busy       (out_busy),
    .out_done       (out_done),
    .out_error      (out_error),
    .out_err_code   (out_err_code),
    .out_sweeps     (out_sweeps),
    .out_fail_value (out_fail_value)
  );

  always #5 in_clock = ~in_clock;

  // Counter model: after sampling start, pos 0..30 gives 0,1..15,14..0 with
  // ready low; pos 31 is the ready-high cycle the checker sees as END.
  logic       m_run;
  int         m_pos, m_sw;
  int         ov_sw, ov_pos, rd_sw, rd_pos;
  logic [3:0] ov_val;
  logic       rd_val, hold0;

  always @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      m_run <= 1'b0; m_pos <= 0; m_sw <= 0;
    end else if (m_run) begin
      if (m_pos == 31) m_run <= 1'b0;
      else             m_pos <= m_pos + 1;
    end else if (out_start) begin
      m_run <= 1'b1; m_pos <= 0; m_sw <= m_sw + 1;
    end
  end

  always_comb begin
    in_value = 4'd0;
    in_ready = 1'b1;
    if (m_run) begin
      if (m_pos <= 15)      in_value = m_pos[3:0];
      else if (m_pos <= 30) in_value = 4'(30 - m_pos);
      in_ready = (m_pos == 31);
      if ((m_sw - 1) == ov_sw && m_pos == ov_pos) in_value = ov_val;
      if ((m_sw - 1) == rd_sw && m_pos == rd_pos) in_ready = rd_val;
    end
    if (hold0) in_ready = 1'b0;
  end

  // Start pulse monitor
  int   cyc = 0;
  int   wide = 0;
  logic prev_st = 1'b0;
  int   st_t[$];

  always @(negedge in_clock) begin
    cyc     <= cyc + 1;
    prev_st <= out_start;
    if (out_start) begin
      st_t.push_back(cyc);
      if (prev_st) wide <= wide + 1;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_ov();
    ov_sw = -1; ov_pos = -1; ov_val = 4'd0;
    rd_sw = -1; rd_pos = -1; rd_val = 1'b0;
    hold0 = 1'b0;
  endtask

  task automatic do_reset();
    in_go = 1'b0;
    @(negedge in_clock);
    in_reset_n = 1'b0;
    repeat (2) @(negedge in_clock);
    in_reset_n = 1'b1;
    @(negedge in_clock);
  endtask

  task automatic pulse_go();
    @(negedge in_clock);
    in_go = 1'b1;
    @(negedge in_clock);
    in_go = 1'b0;
  endtask

  task automatic wait_end(input string name, input int budget);
    int n;
    n = 0;
    while (!(out_done || out_error) && n < budget) begin
      @(negedge in_clock);
      n++;
    end
    chk({name, "_finished"}, int'(out_done || out_error), 1);
  endtask

  typedef struct {
    int         ov_sw, ov_pos;
    logic [3:0] ov_val;
    int         rd_sw, rd_pos;
    logic       rd_val;
    int         e_done, e_err, e_code, e_sweeps, e_fail, e_starts;
  } vec_t;

  vec_t tbl[10];

  initial begin
    clr_ov();
    tbl[0] = '{-1, -1, 4'd0,  -1, -1, 1'b0, 1, 0, 0, 3, 0,  3}; // clean run
    tbl[1] = '{ 0,  8, 4'd9,  -1, -1, 1'b0, 0, 1, 1, 0, 9,  1}; // 9 where 8 expected
    tbl[2] = '{ 1, 20, 4'd3,  -1, -1, 1'b0, 0, 1, 1, 1, 3,  2}; // fall mismatch, sweep 2
    tbl[3] = '{ 0,  0, 4'd5,  -1, -1, 1'b0, 0, 1, 1, 0, 5,  1}; // nonzero at ARM
    tbl[4] = '{-1, -1, 4'd0,   0, 22, 1'b1, 0, 1, 3, 0, 0,  1}; // ready pulse mid-fall
    tbl[5] = '{-1, -1, 4'd0,   2, 31, 1'b0, 0, 1, 3, 2, 0,  3}; // ready low in last END
    tbl[6] = '{ 0,  5, 4'd7,   0,  5, 1'b1, 0, 1, 1, 0, 7,  1}; // value beats ready
    tbl[7] = '{ 1, 15, 4'd14, -1, -1, 1'b0, 0, 1, 1, 1, 14, 2}; // wrong at MAX
    tbl[8] = '{ 2, 30, 4'd15, -1, -1, 1'b0, 0, 1, 1, 2, 15, 3}; // wrap instead of final 0
    tbl[9] = '{-1, -1, 4'd0,   0, 15, 1'b1, 0, 1, 3, 0, 0,  1}; // ready high at MAX

    // Reset state
    #1 in_reset_n = 1'b0;
    #1;
    chk("rst_start",  int'(out_start), 0);
    chk("rst_busy",   int'(out_busy), 0);
    chk("rst_flags",  int'({out_done, out_error}), 0);
    chk("rst_code",   int'(out_err_code), 0);
    chk("rst_sweeps", int'(out_sweeps), 0);
    chk("rst_fail",   int'(out_fail_value), 0);
    repeat (2) @(negedge in_clock);
    in_reset_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      clr_ov();
      do_reset();
      ov_sw = tbl[v].ov_sw; ov_pos = tbl[v].ov_pos; ov_val = tbl[v].ov_val;
      rd_sw = tbl[v].rd_sw; rd_pos = tbl[v].rd_pos; rd_val = tbl[v].rd_val;
      st_t.delete();
      wide = 0;
      pulse_go();
      wait_end($sformatf("v%0d", v), 400);
      repeat (40) @(negedge in_clock);
      chk($sformatf("v%0d_done", v),   int'(out_done),       tbl[v].e_done);
      chk($sformatf("v%0d_error", v),  int'(out_error),      tbl[v].e_err);
      chk($sformatf("v%0d_code", v),   int'(out_err_code),   tbl[v].e_code);
      chk($sformatf("v%0d_sweeps", v), int'(out_sweeps),     tbl[v].e_sweeps);
      chk($sformatf("v%0d_fail", v),   int'(out_fail_value), tbl[v].e_fail);
      chk($sformatf("v%0d_busy", v),   int'(out_busy),       0);
      chk($sformatf("v%0d_starts", v), st_t.size(),          tbl[v].e_starts);
      if (v == 0 && st_t.size() == 3) begin
        // Start-to-start is 34 cycles: 33 quiet cycles between pulses.
        chk("start_period_1", st_t[1] - st_t[0], 34);
        chk("start_period_2", st_t[2] - st_t[1], 34);
        chk("start_width",    wide, 0);
      end
    end

    // Timeout: ready never rises; error lands 32 edges after entering WAIT_RDY.
    clr_ov();
    do_reset();
    hold0 = 1'b1;
    @(negedge in_clock);
    in_go = 1'b1;
    @(posedge in_clock);
    @(negedge in_clock);
    in_go = 1'b0;
    repeat (31) @(posedge in_clock);
    #1;
    chk("tmo_early_err",  int'(out_error), 0);
    chk("tmo_early_busy", int'(out_busy), 1);
    @(posedge in_clock);
    #1;
    chk("tmo_err",  int'(out_error), 1);
    chk("tmo_code", int'(out_err_code), 2);
    chk("tmo_busy", int'(out_busy), 0);
    hold0 = 1'b0;

    // Async reset in the middle of a rise, then a clean rerun.
    clr_ov();
    do_reset();
    pulse_go();
    begin
      int n;
      n = 0;
      while (!(m_run && m_pos == 5) && n < 100) begin
        @(negedge in_clock);
        n++;
      end
      chk("mid_rise_reached", int'(m_run && m_pos == 5), 1);
    end
    chk("mid_rise_busy", int'(out_busy), 1);
    #2 in_reset_n = 1'b0;
    #1;
    chk("arst_outs", int'({out_start, out_busy, out_done, out_error, out_err_code,
                          out_sweeps, out_fail_value}), 0);
    @(negedge in_clock);
    in_reset_n = 1'b1;
    st_t.delete();
    pulse_go();
    wait_end("rerun", 400);
    chk("rerun_done",   int'(out_done), 1);
    chk("rerun_sweeps", int'(out_sweeps), 3);
    chk("rerun_starts", st_t.size(), 3);

    // go during a run is ignored; go in DONE clears and restarts.
    clr_ov();
    do_reset();
    st_t.delete();
    pulse_go();
    repeat (50) @(negedge in_clock);
    pulse_go();
    repeat (20) @(negedge in_clock);
    pulse_go();
    wait_end("gorun", 400);
    chk("gorun_done",   int'(out_done), 1);
    chk("gorun_sweeps", int'(out_sweeps), 3);
    chk("gorun_starts", st_t.size(), 3);
    @(negedge in_clock);
    in_go = 1'b1;
    @(posedge in_clock);
    #1;
    chk("regoi_busy",   int'(out_busy), 1);
    chk("regoi_done",   int'(out_done), 0);
    chk("regoi_sweeps", int'(out_sweeps), 0);
    @(negedge in_clock);
    in_go = 1'b0;
    wait_end("rego", 400);
    chk("rego_done",   int'(out_done), 1);
    chk("rego_error",  int'(out_error), 0);
    chk("rego_sweeps", int'(out_sweeps), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
